lp_pipe_result_buf: RTL and testbench
=====================================

Name: lp_pipe_result_buf

Overview:
- Downstream receiver for the low-power pipe manager's output interface.
- Captures each result (data + ID) pushed out of a managed pipeline into a small FIFO.
- Drives accept_n back to the manager, so the pipe stalls rather than drops results.
- Presents results to the consumer through an active-low pop interface, with status and sticky error flags.

Parameters:
- data_width, 16, width of result data (e.g. product width a_width+b_width)
- id_width, 3, width of result ID (matches manager launch_id/arrive_id)
- depth, 4, result slots; legal range 2..256, any value (not restricted to a power of two)
- af_level, 1, almost_full asserts when free slots <= af_level; legal 0..depth-1
- cnt_width, 3, width of count; must be ceil(log2(depth+1))

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- push_out_n  in  1  active-low push from pipe manager; a result is presented this cycle
- arrive_id  in  id_width  ID of pushed result
- data_in  in  data_width  pushed result data
- accept_n  out  1  active-low; 0 = buffer can take a push this cycle, 1 = stall pipe
- pop_req_n  in  1  active-low pop from consumer
- data_out  out  data_width  head-of-FIFO data
- id_out  out  id_width  head-of-FIFO ID
- empty  out  1  no entries
- full  out  1  depth entries
- almost_full  out  1  free slots <= af_level
- count  out  cnt_width  entries held
- error  out  1  sticky overflow/underflow flag
- id_err  out  1  sticky ID-sequence flag (optional feature)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - wr_ptr=rd_ptr=0, count=0, empty=1, full=0, error=0, id_err=0.
  - almost_full=1 only if af_level>=depth, which is illegal, so 0.
  - accept_n=0; data_out/id_out=0.
  - Storage contents need not be cleared.
  - Reset mid-operation discards all held entries on that edge.
- Status flags:
  - accept_n = full. It is a registered-state function and does not depend on push_out_n or pop_req_n in the same cycle (no combinational path), so the manager sees a stable stall.
  - full, empty, almost_full and count are all decoded from the count register.
- Push: effective when push_out_n=0 and full=0. Writes {arrive_id, data_in} at wr_ptr; wr_ptr advances, wrapping depth-1 -> 0.
- Pop: effective when pop_req_n=0 and empty=0. rd_ptr advances with the same wrap.
- Head outputs:
  - data_out/id_out are the storage at rd_ptr, valid whenever empty=0.
  - First-word latency is 1 cycle: a push at edge N makes empty=0 and the head valid after edge N.
  - When empty=1, data_out/id_out hold the last popped value (don't-care for checks).
- Simultaneous push and pop (non-empty, non-full): both occur and count is unchanged.
- Full + pop: pop occurs. accept_n stays 1 that cycle, so no push is taken. After the edge, full=0 and accept_n=0.
- Empty + push + pop: push occurs, pop is an underflow (see below), and count becomes 1.
- Errors (error is sticky until reset):
  - Overflow: push_out_n=0 while full=1. The push is ignored and error is set next edge. This is a protocol violation by the manager.
  - Underflow: pop_req_n=0 while empty=1. Ignored; error is set.
- count is always in 0..depth; the pointers never equal each other except when empty or full.

Optional Feature:
- Macro: LP_PIPE_RESULT_BUF_ID_CHECK_EN
- Defined:
  - An expected-ID counter (id_width bits, reset 0) increments modulo 2^id_width on each effective push.
  - If an effective push has arrive_id != expected, id_err sets (sticky) on that edge.
  - The counter then resyncs to arrive_id+1.
- Undefined: no counter logic; id_err tied to 0. The port exists in both builds.

Decomposition:
- Shared include/package lp_pipe_pkg holds:
  - the ceil-log2 function used to derive cnt_width;
  - the error-cause encodings OVF=1, UNF=2, used by bench monitors;
  - the common default id_width of 3.
- One sub-module, lp_pipe_result_ram:
  - 1-write/1-read register array of depth x (id_width+data_width);
  - synchronous write, asynchronous read;
  - no reset on storage.

Test Plan:
1. Reset then single push: push_out_n=0 for one cycle with id=3, data=0x00A5. Next cycle: empty=0, count=1, id_out=3, data_out=0x00A5, accept_n=0.
2. Fill: 4 pushes with ids 0..3 and no pop (depth=4). After the 3rd push almost_full=1; after the 4th, full=1 and accept_n=1. A 5th push_out_n=0 sets error=1, count stays 4, contents unchanged.
3. Drain order: after test 2, pop 4 times. Outputs are ids 0,1,2,3 in order. Then empty=1 and count=0. A further pop sets error=1.
4. Wrap with concurrent traffic: 20 cycles of push and pop both asserted starting at count=2. count stays 2, no error, and output order matches input order across pointer wrap.
5. Full+pop: at full, assert pop_req_n=0 and push_out_n=0 together. Pop is taken and push is ignored without error (accept_n=1, the manager holds). Next cycle accept_n=0 and the retried push is accepted.
6. ID check (macro defined): push ids 0,1,3. id_err=1 after the third push. A subsequent id 4 causes no further flag change. With the macro undefined, id_err stays 0.

Source files
------------

// File: rtl/lp_pipe_pkg.sv
// Shared definitions for the low-power pipe result path: default ID width,
// error-cause encodings and the ceil-log2 helper used to size counters.
package lp_pipe_pkg;

    localparam int LP_ID_WIDTH = 3;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_OVF  = 2'd1,
        ERR_UNF  = 2'd2
    } err_cause_t;

    // Smallest r with 2**r >= value; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < value) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lp_pipe_result_ram.sv
// Result storage: depth x width register array, synchronous write,
// asynchronous read.
module lp_pipe_result_ram #(
    parameter int depth      = 4,
    parameter int width      = 19,
    parameter int addr_width = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [width-1:0]      wdata,
    input  logic [addr_width-1:0] raddr,
    output logic [width-1:0]      rdata
);

    logic [width-1:0] mem [depth];

    // NOTE: storage has no reset; the count register alone decides which
    // slots are meaningful, so clearing the array would only cost flops.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lp_pipe_result_buf.sv
// Result FIFO between the pipe manager and its consumer; accept_n stalls the
// pipe when full. Optional ID-sequence checker: LP_PIPE_RESULT_BUF_ID_CHECK_EN.
module lp_pipe_result_buf
    import lp_pipe_pkg::*;
#(
    parameter int data_width = 16,
    parameter int id_width   = LP_ID_WIDTH,
    parameter int depth      = 4,
    parameter int af_level   = 1,
    parameter int cnt_width  = clog2(depth + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_out_n,
    input  logic [id_width-1:0]   arrive_id,
    input  logic [data_width-1:0] data_in,
    output logic                  accept_n,
    input  logic                  pop_req_n,
    output logic [data_width-1:0] data_out,
    output logic [id_width-1:0]   id_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [cnt_width-1:0]  count,
    output logic                  error,
    output logic                  id_err
);

    localparam int ptr_width   = clog2(depth);
    localparam int entry_width = id_width + data_width;

    logic [ptr_width-1:0]   wr_ptr;
    logic [ptr_width-1:0]   rd_ptr;
    logic [entry_width-1:0] head_entry;
    logic [entry_width-1:0] last_popped;
    logic                   push_eff;
    logic                   pop_eff;
    err_cause_t             err_cause;

    function automatic logic [ptr_width-1:0] ptr_inc(input logic [ptr_width-1:0] p);
        return (p == ptr_width'(depth - 1)) ? '0 : p + ptr_width'(1);
    endfunction

    // Every status flag is a pure decode of the count register, so accept_n
    // never depends on this cycle's push or pop request.
    assign empty       = (count == '0);
    assign full        = (count == cnt_width'(depth));
    assign almost_full = (depth - int'(count)) <= af_level;
    assign accept_n    = full;

    assign push_eff = !push_out_n && !full;
    assign pop_eff  = !pop_req_n && !empty;

    // A push held against a full buffer while the consumer drains is the
    // normal stall handshake, not an overflow.
    always_comb begin
        // NOTE: default first so every path assigns err_cause and no latch forms.
        err_cause = ERR_NONE;
        if (!pop_req_n && empty) begin
            err_cause = ERR_UNF;
        end else if (!push_out_n && full && pop_req_n) begin
            err_cause = ERR_OVF;
        end
    end

    // NOTE: non-blocking assignments keep every register reading pre-edge
    // values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            error       <= 1'b0;
            last_popped <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_eff) begin
                rd_ptr      <= ptr_inc(rd_ptr);
                last_popped <= head_entry;
            end
            count <= count + cnt_width'(push_eff) - cnt_width'(pop_eff);
            if (err_cause != ERR_NONE) begin
                error <= 1'b1;
            end
        end
    end

    lp_pipe_result_ram #(
        .depth      (depth),
        .width      (entry_width),
        .addr_width (ptr_width)
    ) u_ram (
        .clk   (clk),
        .we    (push_eff),
        .waddr (wr_ptr),
        .wdata ({arrive_id, data_in}),
        .raddr (rd_ptr),
        .rdata (head_entry)
    );

    // While empty the head shows the last popped result (zero after reset).
    assign {id_out, data_out} = empty ? last_popped : head_entry;

`ifdef LP_PIPE_RESULT_BUF_ID_CHECK_EN
    logic [id_width-1:0] exp_id;
    logic                id_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_id   <= '0;
            id_err_q <= 1'b0;
        end else if (push_eff) begin
            if (arrive_id != exp_id) begin
                id_err_q <= 1'b1;
            end
            exp_id <= arrive_id + id_width'(1);
        end
    end

    assign id_err = id_err_q;
`else
    assign id_err = 1'b0;
`endif

endmodule

// File: tb/tb_lp_pipe_result_buf.sv
// Scoreboard bench for lp_pipe_result_buf: directed scenarios, then random
// traffic checked against a queue-based reference model.
module tb_lp_pipe_result_buf;
    import lp_pipe_pkg::*;

    localparam int DW    = 16;
    localparam int IW    = LP_ID_WIDTH;
    localparam int DEPTH = 4;
    localparam int AF    = 1;
    localparam int CW    = clog2(DEPTH + 1);
    localparam int EW    = IW + DW;

    typedef logic [EW-1:0] entry_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          push_out_n = 1'b1;
    logic [IW-1:0] arrive_id = '0;
    logic [DW-1:0] data_in = '0;
    logic          accept_n;
    logic          pop_req_n = 1'b1;
    logic [DW-1:0] data_out;
    logic [IW-1:0] id_out;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic [CW-1:0] count;
    logic          error;
    logic          id_err;

    always #5 clk = ~clk;

    lp_pipe_result_buf #(
        .data_width (DW),
        .id_width   (IW),
        .depth      (DEPTH),
        .af_level   (AF),
        .cnt_width  (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_out_n  (push_out_n),
        .arrive_id   (arrive_id),
        .data_in     (data_in),
        .accept_n    (accept_n),
        .pop_req_n   (pop_req_n),
        .data_out    (data_out),
        .id_out      (id_out),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .error       (error),
        .id_err      (id_err)
    );

    // Reference model: buffer contents, sticky flags, expected next ID.
    entry_t        mdl[$];
    entry_t        sb_q[$];
    bit            mdl_err;
    bit            mdl_id_err;
    logic [IW-1:0] mdl_exp_id;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        int n;
        n = mdl.size();
        check("count", 32'(count), 32'(n));
        check("empty", 32'(empty), 32'(n == 0));
        check("full", 32'(full), 32'(n == DEPTH));
        check("almost_full", 32'(almost_full), 32'((DEPTH - n) <= AF));
        check("accept_n", 32'(accept_n), 32'(n == DEPTH));
        check("error", 32'(error), 32'(mdl_err));
        check("id_err", 32'(id_err), 32'(mdl_id_err));
        if (n > 0) begin
            check("head", 32'({id_out, data_out}), 32'(mdl[0]));
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        push_out_n = 1'b1;
        pop_req_n  = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mdl.delete();
        sb_q.delete();
        mdl_err    = 1'b0;
        mdl_id_err = 1'b0;
        mdl_exp_id = '0;
        check_state();
        check("reset_data_out", 32'(data_out), 32'd0);
        check("reset_id_out", 32'(id_out), 32'd0);
    endtask

    // One clock of stimulus; the model is advanced from the pre-edge contents.
    task automatic step(input bit push, input logic [IW-1:0] id, input logic [DW-1:0] data,
                        input bit pop);
        int         n;
        err_cause_t cause;
        n     = mdl.size();
        cause = ERR_NONE;
        if (pop && n == 0) cause = ERR_UNF;
        else if (push && n == DEPTH && !pop) cause = ERR_OVF;
        if (cause != ERR_NONE) mdl_err = 1'b1;
        if (pop && n > 0) void'(mdl.pop_front());
        if (push && n < DEPTH) begin
            mdl.push_back({id, data});
            sb_q.push_back({id, data});
`ifdef LP_PIPE_RESULT_BUF_ID_CHECK_EN
            if (id != mdl_exp_id) mdl_id_err = 1'b1;
            mdl_exp_id = id + IW'(1);
`endif
        end
        push_out_n = !push;
        arrive_id  = id;
        data_in    = data;
        pop_req_n  = !pop;
        @(posedge clk);
        #1;
        push_out_n = 1'b1;
        pop_req_n  = 1'b1;
        check_state();
    endtask

    // Monitor: every effective pop must present the oldest accepted result.
    always @(negedge clk) begin
        if (rst_n && !pop_req_n && !empty) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_order: DUT popped 0x%0h with no result outstanding",
                         {id_out, data_out});
            end else begin
                check("pop_order", 32'({id_out, data_out}), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        mdl_err    = 1'b0;
        mdl_id_err = 1'b0;
        mdl_exp_id = '0;
        repeat (2) @(posedge clk);
        do_reset();

        // Single push, first-word latency of one edge.
        step(1, 3'd3, 16'h00A5, 0);

        // Fill from an empty buffer, then overflow attempt.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, IW'(i), DW'(16'h1000 + i), 0);
        step(1, 3'd7, 16'hDEAD, 0);

        // Drain in order, then underflow.
        for (int i = 0; i < DEPTH; i++) step(0, '0, '0, 1);
        step(0, '0, '0, 1);

        // Concurrent push/pop across pointer wrap at count 2.
        do_reset();
        step(1, 3'd0, 16'h2000, 0);
        step(1, 3'd1, 16'h2001, 0);
        for (int i = 0; i < 20; i++) step(1, IW'(i + 2), DW'(16'h2100 + i), 1);

        // Full + pop with a held push, then the retried push.
        step(1, 3'd6, 16'h3000, 0);
        step(1, 3'd7, 16'h3001, 0);
        step(1, 3'd0, 16'h3002, 1);
        step(1, 3'd0, 16'h3002, 0);

        // ID sequence 0,1,3,4.
        do_reset();
        step(1, 3'd0, 16'h4000, 0);
        step(1, 3'd1, 16'h4001, 0);
        step(1, 3'd3, 16'h4003, 0);
        step(1, 3'd4, 16'h4004, 0);

        // Random traffic with occasional mid-operation resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(63) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(99) < 55), IW'($urandom), DW'($urandom),
                     ($urandom_range(99) < 50));
            end
        end

        while (mdl.size() > 0) step(0, '0, '0, 1);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
